// File: rtl/memory_io_pkg.sv
// rtl/memory_io_pkg.sv - shared constants, select type and parameter checks for memory_io_control
package memory_io_pkg;

    localparam int IO_OUT_BASE = 0;
    localparam int IO_IN_BASE  = 8;
    localparam int IO_EVT_OFS  = 15;

    typedef enum logic {
        SEL_RAM = 1'b0,
        SEL_IO  = 1'b1
    } sel_t;

    function automatic bit params_ok(
        input int addr_w,
        input int data_w,
        input int ram_aw,
        input int n_out,
        input int out_w,
        input int n_in,
        input int in_w
    );
        return (addr_w >= 5) && (ram_aw >= 1) && (ram_aw <= addr_w - 1) &&
               (n_out >= 1) && (n_out <= 8) && (out_w >= 1) && (out_w <= data_w) &&
               (n_in >= 1) && (n_in <= 7) && (in_w >= 1) && (in_w <= data_w);
    endfunction

endpackage

// File: rtl/memory_io_control_io_in_sync.sv
// rtl/memory_io_control_io_in_sync.sv - 2-flop input synchroniser with change detection
module io_in_sync #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_arm,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync,
    output logic         o_change
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    // While disarmed, the previous-value flop follows the first stage so that
    // the synchroniser filling up after reset never looks like a change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= i_arm ? r_sync : r_meta;
        end
    end

    assign o_sync   = r_sync;
    assign o_change = i_arm && (r_sync != r_prev);

endmodule

// File: rtl/memory_io_control.sv
// rtl/memory_io_control.sv - data-side RAM/I-O address decoder with memory-mapped I/O registers
module memory_io_control
    import memory_io_pkg::*;
#(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 32,
    parameter int                RAM_AW    = 10,
    parameter int                N_OUT     = 4,
    parameter int                OUT_W     = 21,
    parameter logic [DATA_W-1:0] OUT_RESET = '0,
    parameter int                N_IN      = 2,
    parameter int                IN_W      = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   d_rw,
    input  logic [ADDR_W-1:0]      daddr,
    input  logic [DATA_W-1:0]      ddata_w,
    output logic [DATA_W-1:0]      ddata_r,
    output logic [RAM_AW-1:0]      mem_addr,
    output logic                   mem_we,
    output logic [DATA_W-1:0]      mem_dw,
    input  logic [DATA_W-1:0]      mem_dr,
    output logic [N_OUT*OUT_W-1:0] out_dout,
    output logic [N_OUT-1:0]       out_wstb,
    input  logic [N_IN*IN_W-1:0]   io_in,
    output logic                   io_event
);

    if (!params_ok(ADDR_W, DATA_W, RAM_AW, N_OUT, OUT_W, N_IN, IN_W)) begin : g_param_err
        $error("memory_io_control: parameter out of range");
    end

    logic              w_is_io;
    logic [3:0]        w_ofs;
    logic              w_io_wr;
    logic [N_OUT-1:0]  w_out_we;
    logic [N_IN-1:0]   w_evt_clr;
    logic [N_IN-1:0]   w_chg;
    logic              w_arm;
    logic [IN_W-1:0]   w_sync [N_IN];
    logic [DATA_W-1:0] w_io_rdata;

    logic [OUT_W-1:0]  r_out [N_OUT];
    logic [N_OUT-1:0]  r_wstb;
    logic [N_IN-1:0]   r_evt;
    logic [1:0]        r_arm_cnt;
    sel_t              r_sel;
    logic [DATA_W-1:0] r_io_rdata;

    assign w_is_io  = daddr[ADDR_W-1];
    assign w_ofs    = daddr[3:0];
    assign w_io_wr  = d_rw && w_is_io;
    assign mem_addr = daddr[RAM_AW-1:0];
    assign mem_dw   = ddata_w;
    assign mem_we   = d_rw && !w_is_io;
    assign w_arm    = (r_arm_cnt == 2'd2);

    always_comb begin
        w_out_we = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_out_we[k] = w_io_wr && (w_ofs == 4'(IO_OUT_BASE + k));
        end
        w_evt_clr = (w_io_wr && (w_ofs == 4'(IO_EVT_OFS))) ? ddata_w[N_IN-1:0] : '0;
    end

    always_comb begin
        w_io_rdata = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_ofs == 4'(IO_OUT_BASE + k)) w_io_rdata = DATA_W'(r_out[k]);
        end
        for (int i = 0; i < N_IN; i++) begin
            if (w_ofs == 4'(IO_IN_BASE + i)) w_io_rdata = DATA_W'(w_sync[i]);
        end
        if (w_ofs == 4'(IO_EVT_OFS)) w_io_rdata = DATA_W'(r_evt);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_OUT; k++) r_out[k] <= OUT_RESET[OUT_W-1:0];
            r_wstb <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (w_out_we[k]) r_out[k] <= ddata_w[OUT_W-1:0];
            end
            r_wstb <= w_out_we;
        end
    end

    // A change on the same edge as a write-1-to-clear keeps the bit set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= '0;
            r_evt     <= '0;
        end else begin
            if (!w_arm) r_arm_cnt <= r_arm_cnt + 2'd1;
            r_evt <= (r_evt & ~w_evt_clr) | w_chg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel      <= SEL_RAM;
            r_io_rdata <= '0;
        end else begin
            r_sel      <= w_is_io ? SEL_IO : SEL_RAM;
            r_io_rdata <= w_io_rdata;
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        io_in_sync #(.W(IN_W)) u_sync (
            .clock    (clock),
            .reset    (reset),
            .i_arm    (w_arm),
            .i_async  (io_in[i*IN_W +: IN_W]),
            .o_sync   (w_sync[i]),
            .o_change (w_chg[i])
        );
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_dout[k*OUT_W +: OUT_W] = r_out[k];
    end

    assign out_wstb = r_wstb;
    assign io_event = |r_evt;
    assign ddata_r  = (r_sel == SEL_IO) ? r_io_rdata : mem_dr;

endmodule
